// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: run-control and commit-trace block for simpleMIPS bring-up.
// Counts RUN cycles and instructions and ends the run on a branch-to-self halt
// or a cycle timeout. Register-file commits are buffered in a FIFO that is
// drained over a valid/ready port.
// Optional feature: define TRACE_SIGNATURE_EN to add a 32-bit rolling
// signature over all captured commits.
module cpu_trace_monitor #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 400,
    parameter int HALT_REPEAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] npc,
    input  logic              reg_wr,
    input  logic [4:0]        reg_waddr,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [ADDR_W-1:0] trace_pc,
    output logic [4:0]        trace_waddr,
    output logic [DATA_W-1:0] trace_wdata,
    output logic              done,
    output logic              halted,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic              overflow,
    output logic [7:0]        drop_cnt
`ifdef TRACE_SIGNATURE_EN
    ,
    output logic [31:0]       signature
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int HR_W = $clog2(HALT_REPEAT + 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_TIMEOUT} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [4:0]        waddr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    state_t            state;
    logic [HR_W-1:0]   halt_rep;
    logic [HR_W-1:0]   rep_next;
    logic [CNT_W-1:0]  cycle_next;
    logic              halt_hit;
    logic              timeout_hit;

    entry_t            mem [DEPTH];
    entry_t            in_entry;
    entry_t            head_next;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_next;
    logic [AW:0]       count;
    logic [AW:0]       after_pop;
    logic              capture;
    logic              pop;
    logic              full;
    logic              push;
    logic              drop;

    // Run-control next-state terms: halt repeat and saturating cycle count.
    assign rep_next    = (pc == npc) ? halt_rep + 1'b1 : '0;
    assign cycle_next  = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 1'b1;
    assign halt_hit    = (rep_next == HR_W'(HALT_REPEAT));
    assign timeout_hit = (cycle_next == CNT_W'(MAX_CYCLES));

    // Commit capture and FIFO handshake terms.
    assign capture     = (state == S_RUN) && reg_wr && (reg_waddr != 5'd0);
    assign pop         = trace_valid && trace_ready;
    assign full        = (count == FULL_CNT);
    assign push        = capture && (!full || pop);
    assign drop        = capture && full && !pop;
    assign in_entry    = {pc, reg_waddr, reg_wdata};
    assign rd_ptr_next = rd_ptr + AW'(pop);
    assign after_pop   = count - (AW + 1)'(pop);

    // Head of the FIFO after this edge; an entry pushed into an otherwise empty
    // FIFO bypasses storage so it appears exactly one cycle after the push.
    always_comb begin
        head_next = mem[rd_ptr_next];
        if (push && (after_pop == '0))
            head_next = in_entry;
    end

    // Run-control FSM: IDLE -> RUN -> HALTED | TIMEOUT, with registered status.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= S_IDLE;
            halt_rep  <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en)
                        state <= S_RUN;
                end
                S_RUN: begin
                    cycle_cnt <= cycle_next;
                    halt_rep  <= rep_next;
                    if ((pc != npc) && (instr_cnt != '1))
                        instr_cnt <= instr_cnt + 1'b1;
                    // Halt takes priority when both conditions land on one edge.
                    if (halt_hit) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                        done   <= 1'b1;
                    end else if (timeout_hit) begin
                        state   <= S_TIMEOUT;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                default: ; // HALTED and TIMEOUT are terminal until reset
            endcase
        end
    end

    // FIFO control: pointers, occupancy, registered head and drop accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_waddr <= '0;
            trace_wdata <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            rd_ptr <= rd_ptr_next;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
            trace_valid <= (after_pop != '0) || push;
            // An empty FIFO keeps presenting the last popped entry.
            if ((after_pop != '0) || push)
                {trace_pc, trace_waddr, trace_wdata} <= head_next;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy and pointers are
        // reset, so stale words are never presented as valid.
        if (push)
            mem[wr_ptr] <= in_entry;
    end

`ifdef TRACE_SIGNATURE_EN
    // Rolling signature over every captured commit, including dropped ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            signature <= '0;
        else if (capture)
            signature <= {signature[30:0], signature[31]} ^ reg_wdata[31:0]
                         ^ {27'b0, reg_waddr};
    end
`endif

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor with a commit scoreboard: expected
// trace entries are queued when a capturable commit is driven and compared
// when the FIFO presents and pops them.
module tb_cpu_trace_monitor;

    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        reg_wr;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_waddr;
    logic [31:0] trace_wdata;
    logic        done;
    logic        halted;
    logic        timeout;
    logic [15:0] cycle_cnt;
    logic [15:0] instr_cnt;
    logic        overflow;
    logic [7:0]  drop_cnt;
`ifdef TRACE_SIGNATURE_EN
    logic [31:0] signature;
`endif

    cpu_trace_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pc          (pc),
        .npc         (npc),
        .reg_wr      (reg_wr),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_pc    (trace_pc),
        .trace_waddr (trace_waddr),
        .trace_wdata (trace_wdata),
        .done        (done),
        .halted      (halted),
        .timeout     (timeout),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
`ifdef TRACE_SIGNATURE_EN
        ,
        .signature   (signature)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks     = 0;
    int   failures   = 0;
    int   exp_drops  = 0;
    int   pops       = 0;
    bit   run_active = 1'b0;
    bit   mon_en     = 1'b0;
    exp_t sb[$];
    exp_t last_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: sampled on the falling edge, it checks the FIFO head
    // against the model, retires the entry that pops on the next rising edge,
    // and queues the commit the next rising edge will capture.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            chk("valid_vs_model", trace_valid, sb.size() != 0);
            if (trace_valid && sb.size() != 0) begin
                chk("head_pc", trace_pc, sb[0].pc);
                chk("head_waddr", trace_waddr, sb[0].waddr);
                chk("head_wdata", trace_wdata, sb[0].wdata);
                if (trace_ready) begin
                    last_e = sb.pop_front();
                    pops++;
                end
            end else if (!trace_valid) begin
                chk("hold_last_pc", trace_pc, last_e.pc);
                chk("hold_last_wdata", trace_wdata, last_e.wdata);
            end
            if (run_active && reg_wr && reg_waddr != 5'd0) begin
                if (sb.size() < DEPTH)
                    sb.push_back('{pc, reg_waddr, reg_wdata});
                else
                    exp_drops++;
            end
        end
    end

    // Present one cycle of CPU activity; returns just after the capturing edge.
    task automatic drive(input logic [31:0] p, input logic [31:0] n, input logic w,
                         input logic [4:0] a, input logic [31:0] d);
        pc        = p;
        npc       = n;
        reg_wr    = w;
        reg_waddr = a;
        reg_wdata = d;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse of 20 time units, checked while asserted.
    task automatic do_reset();
        rst         = 1'b1;
        en          = 1'b0;
        reg_wr      = 1'b0;
        trace_ready = 1'b0;
        #1;
        chk("rst_flags", {done, halted, timeout, trace_valid, overflow}, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_instr_cnt", instr_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_trace", {trace_pc, trace_waddr, trace_wdata}, 0);
`ifdef TRACE_SIGNATURE_EN
        chk("rst_signature", signature, 0);
`endif
        sb.delete();
        run_active = 1'b0;
        exp_drops  = 0;
        pops       = 0;
        last_e     = '{32'h0, 5'h0, 32'h0};
        #19;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Request a run; the FSM is in RUN once this returns.
    task automatic start_run();
        en = 1'b1;
        @(posedge clk);
        #1;
        en         = 1'b0;
        run_active = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b0; pc = '0; npc = '0;
        reg_wr = 1'b0; reg_waddr = '0; reg_wdata = '0; trace_ready = 1'b0;
        #3;
        do_reset();

        // Halt: two commits, then branch-to-self until the fourth stall cycle.
        start_run();
        trace_ready = 1'b1;
        drive(32'h14, 32'h18, 1'b1, 5'd8, 32'h5);
        drive(32'h18, 32'h1C, 1'b1, 5'd9, 32'hA);
        repeat (3) drive(32'h1C, 32'h1C, 1'b0, 5'd0, 32'h0);
        chk("halt_not_yet", {halted, done}, 0);
        drive(32'h1C, 32'h1C, 1'b0, 5'd0, 32'h0);
        run_active = 1'b0;
        chk("halt_flags", {halted, done, timeout}, 3'b110);
        chk("halt_cycle_cnt", cycle_cnt, 6);
        chk("halt_instr_cnt", instr_cnt, 2);
        en = 1'b1;
        drive(32'h20, 32'h24, 1'b1, 5'd11, 32'h77);
        en = 1'b0;
        repeat (2) drive(32'h24, 32'h28, 1'b0, 5'd0, 32'h0);
        chk("halt_frozen_cnt", cycle_cnt, 6);
        chk("halt_terminal", {halted, timeout}, 2'b10);
        chk("halt_pops", pops, 2);
        chk("halt_last_entry", {trace_pc, trace_waddr, trace_wdata}, {32'h18, 5'd9, 32'hA});

        // Timeout: pc never equals npc.
        do_reset();
        start_run();
        repeat (399) drive(32'h100, 32'h104, 1'b0, 5'd0, 32'h0);
        chk("to_not_yet", done, 0);
        chk("to_cycle_399", cycle_cnt, 399);
        drive(32'h100, 32'h104, 1'b0, 5'd0, 32'h0);
        run_active = 1'b0;
        chk("to_flags", {timeout, halted, done}, 3'b101);
        chk("to_cycle_cnt", cycle_cnt, 400);
        chk("to_instr_cnt", instr_cnt, 400);
        repeat (3) drive(32'h100, 32'h100, 1'b0, 5'd0, 32'h0);
        chk("to_frozen", {cycle_cnt, instr_cnt, halted}, {16'd400, 16'd400, 1'b0});

        // Halt and timeout decided on the same edge: halt wins.
        do_reset();
        start_run();
        repeat (396) drive(32'h200, 32'h204, 1'b0, 5'd0, 32'h0);
        repeat (3) drive(32'h1C, 32'h1C, 1'b0, 5'd0, 32'h0);
        drive(32'h1C, 32'h1C, 1'b0, 5'd0, 32'h0);
        run_active = 1'b0;
        chk("tie_flags", {halted, timeout, done}, 3'b101);
        chk("tie_cycle_cnt", cycle_cnt, 400);

        // Reset mid-run clears everything, including a held FIFO entry.
        do_reset();
        start_run();
        drive(32'h40, 32'h44, 1'b1, 5'd3, 32'h33);
        repeat (9) drive(32'h44, 32'h48, 1'b0, 5'd0, 32'h0);
        chk("mid_cycle_cnt", cycle_cnt, 10);
        chk("mid_valid", trace_valid, 1);
        #2;
        do_reset();
        chk("mid_idle_cnt", cycle_cnt, 0);
        start_run();
        drive(32'h50, 32'h54, 1'b0, 5'd0, 32'h0);
        chk("mid_restart_cnt", {cycle_cnt, instr_cnt}, {16'd1, 16'd1});

        // Overflow: 20 commits into a stalled FIFO, then full+pop+push.
        do_reset();
        start_run();
        for (int i = 0; i < 20; i++)
            drive(32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i), 1'b1,
                  5'(i % 31 + 1), 32'hA000 + 32'(i));
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop_cnt", drop_cnt, 4);
        chk("ovf_drop_model", drop_cnt, exp_drops);
        trace_ready = 1'b1;
        drive(32'h2000, 32'h2004, 1'b1, 5'd7, 32'hBEEF);
        chk("ovf_full_pop_push", drop_cnt, 4);
        for (int n = 0; n < 40 && sb.size() != 0; n++)
            drive(32'h2004, 32'h2008, 1'b0, 5'd0, 32'h0);
        chk("ovf_drained", sb.size(), 0);
        chk("ovf_pops", pops, 17);
        chk("ovf_empty_hold", {trace_valid, trace_waddr, trace_wdata}, {1'b0, 5'd7, 32'hBEEF});

        // $0 filter with trace_ready toggling every cycle.
        do_reset();
        start_run();
        begin
            logic [4:0]  wa [6];
            logic [31:0] wd [6];
            wa = '{5'd0, 5'd5, 5'd6, 5'd0, 5'd7, 5'd10};
            wd = '{32'hFFFFFFFF, 32'h55, 32'h66, 32'hFFFFFFFF, 32'h77, 32'hAA};
            for (int i = 0; i < 6; i++) begin
                trace_ready = i[0];
                drive(32'h300 + 32'(4 * i), 32'h304 + 32'(4 * i), 1'b1, wa[i], wd[i]);
            end
        end
        for (int n = 0; n < 40 && sb.size() != 0; n++) begin
            trace_ready = ~trace_ready;
            drive(32'h320, 32'h324, 1'b0, 5'd0, 32'h0);
        end
        chk("bp_drained", sb.size(), 0);
        chk("bp_pops", pops, 4);
        chk("bp_no_drop", {overflow, drop_cnt}, 0);
        chk("bp_last", {trace_valid, trace_waddr, trace_wdata}, {1'b0, 5'd10, 32'hAA});

`ifdef TRACE_SIGNATURE_EN
        // Signature over ($1=1), ($2=2), ($3=0x10).
        do_reset();
        start_run();
        trace_ready = 1'b1;
        drive(32'h400, 32'h404, 1'b1, 5'd1, 32'h1);
        chk("sig_1", signature, 32'h0);
        drive(32'h404, 32'h408, 1'b1, 5'd2, 32'h2);
        chk("sig_2", signature, 32'h0);
        drive(32'h408, 32'h40C, 1'b1, 5'd3, 32'h10);
        chk("sig_3", signature, 32'h13);
        repeat (3) drive(32'h40C, 32'h410, 1'b0, 5'd0, 32'h0);
`endif

        reg_wr = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
